// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the board display (six seven-segment digits + ten LEDs).
// Each owner keeps the display for a minimum slice; a one-cycle blank separates owners.
module disp_share_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter int          HOLD_CYCLES = 50000000,
   parameter logic [7:0]  HEX_OFF     = 8'hFF
) (
   input  logic                    max10_clk1_50,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*48-1:0]   req_hex,
   input  logic [NUM_REQ*10-1:0]   req_led,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    busy,
   output logic [7:0]              hex0,
   output logic [7:0]              hex1,
   output logic [7:0]              hex2,
   output logic [7:0]              hex3,
   output logic [7:0]              hex4,
   output logic [7:0]              hex5,
   output logic [9:0]              ledr,
   output logic [1:0]              o_dbg_state
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN   = 2'd1,
      S_BLANK = 2'd2
   } state_t;

   state_t               r_state;
   logic [IW-1:0]        r_ptr;
   logic [IW-1:0]        r_owner;
   logic [CW-1:0]        r_cnt;
   logic [NUM_REQ-1:0]   r_grant;
   logic [47:0]          r_hex;
   logic [9:0]           r_led;

   state_t               w_state_nxt;
   logic [IW-1:0]        w_ptr_nxt;
   logic [IW-1:0]        w_owner_nxt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [NUM_REQ-1:0]   w_grant_nxt;
   logic [47:0]          w_hex_nxt;
   logic [9:0]           w_led_nxt;

   logic                 w_found;
   logic [IW-1:0]        w_win;
   logic                 w_others;
   logic                 w_exit;

   // First asserted request at or after the pointer, wrapping past the top index.
   always_comb begin : p_win
      int v_idx;
      w_found = 1'b0;
      w_win   = '0;
      v_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = int'(r_ptr) + k;
         if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
         if (!w_found && req[v_idx]) begin
            w_found = 1'b1;
            w_win   = IW'(v_idx);
         end
      end
   end

   assign w_others = |(req & ~r_grant);
   assign w_exit   = !req[r_owner] || ((r_cnt == CNT_MAX) && w_others);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_grant_nxt = '0;
      w_hex_nxt   = {6{HEX_OFF}};
      w_led_nxt   = '0;
      case (r_state)
         S_IDLE, S_BLANK: begin
            if (w_found) begin
               w_state_nxt = S_OWN;
               w_owner_nxt = w_win;
               w_cnt_nxt   = '0;
               w_grant_nxt = ONE << w_win;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_OWN: begin
            if (w_exit) begin
               w_state_nxt = S_BLANK;
               w_ptr_nxt   = (r_owner == IDX_LAST) ? '0 : r_owner + 1'b1;
            end else begin
               // Owner data is sampled only while ownership continues, so the
               // blank cycle never carries a stale segment pattern.
               w_grant_nxt = r_grant;
               w_hex_nxt   = req_hex[48*r_owner +: 48];
               w_led_nxt   = req_led[10*r_owner +: 10];
               if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge max10_clk1_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
         r_grant <= '0;
         r_hex   <= {6{HEX_OFF}};
         r_led   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
         r_grant <= w_grant_nxt;
         r_hex   <= w_hex_nxt;
         r_led   <= w_led_nxt;
      end
   end

   assign grant       = r_grant;
   assign busy        = (r_state == S_OWN);
   assign hex0        = r_hex[7:0];
   assign hex1        = r_hex[15:8];
   assign hex2        = r_hex[23:16];
   assign hex3        = r_hex[31:24];
   assign hex4        = r_hex[39:32];
   assign hex5        = r_hex[47:40];
   assign ledr        = r_led;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
module tb_disp_share_arbiter;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req;
   logic [191:0] req_hex;
   logic [39:0]  req_led;
   logic [3:0]   grant;
   logic         busy;
   logic [7:0]   hex0, hex1, hex2, hex3, hex4, hex5;
   logic [9:0]   ledr;
   logic [1:0]   dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OWN   = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;
   localparam logic [47:0] ALL_OFF = 48'hFFFF_FFFF_FFFF;

   disp_share_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4), .HEX_OFF(8'hFF)) dut (
      .max10_clk1_50(clk),
      .reset_n(rst_n),
      .req(req),
      .req_hex(req_hex),
      .req_led(req_led),
      .grant(grant),
      .busy(busy),
      .hex0(hex0),
      .hex1(hex1),
      .hex2(hex2),
      .hex3(hex3),
      .hex4(hex4),
      .hex5(hex5),
      .ledr(ledr),
      .o_dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] hex_all();
      return {hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   initial begin
      logic [3:0] seq_g [4];
      logic [7:0] seq_h [4];
      seq_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      seq_h = '{8'hA5, 8'hB5, 8'hD5, 8'hA5};

      rst_n   = 1'b0;
      req     = 4'b0000;
      req_hex = {48'hD0D1D2D3D4D5, 48'h0123456789AB, 48'hB0B1B2B3B4B5, 48'hA0A1A2A3A4A5};
      req_led = {10'h3C0, 10'h155, 10'h002, 10'h001};

      // Reset values
      #35;
      chk("rst_grant", 48'(grant), 48'h0);
      chk("rst_busy", 48'(busy), 48'h0);
      chk("rst_hex", hex_all(), ALL_OFF);
      chk("rst_ledr", 48'(ledr), 48'h0);
      chk("rst_state", 48'(dbg_state), 48'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("idle_grant", 48'(grant), 48'h0);

      // Single requester 2, held well past the slice
      req = 4'b0100;
      step();
      chk("single_grant", 48'(grant), 48'b0100);
      chk("single_busy", 48'(busy), 48'h1);
      chk("single_hex_first", hex_all(), ALL_OFF);
      step();
      chk("single_hex0", 48'(hex0), 48'hAB);
      chk("single_hex5", 48'(hex5), 48'h01);
      chk("single_ledr", 48'(ledr), 48'h155);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("single_hold", 48'(grant), 48'b0100);
      end

      // Owner LED pass-through, non-owner change ignored
      req_led[29:20] = 10'h2AA;
      step();
      chk("pass_owner_led", 48'(ledr), 48'h2AA);
      req_led[9:0] = 10'h3FF;
      step();
      chk("pass_other_led", 48'(ledr), 48'h2AA);

      req = 4'b0000;
      step();
      chk("rel_blank_state", 48'(dbg_state), 48'(ST_BLANK));
      chk("rel_blank_grant", 48'(grant), 48'h0);
      chk("rel_blank_hex", hex_all(), ALL_OFF);
      chk("rel_blank_ledr", 48'(ledr), 48'h0);
      step();
      chk("rel_idle_state", 48'(dbg_state), 48'(ST_IDLE));

      // Pointer now 3; lone request 0 wins by wrapping
      req = 4'b0001;
      step();
      chk("wrap_grant", 48'(grant), 48'b0001);
      step();
      chk("wrap_hex", hex_all(), 48'hA0A1A2A3A4A5);
      chk("wrap_ledr", 48'(ledr), 48'h3FF);

      // Asynchronous reset between clock edges
      #3;
      rst_n = 1'b0;
      #1;
      chk("amid_grant", 48'(grant), 48'h0);
      chk("amid_busy", 48'(busy), 48'h0);
      chk("amid_hex", hex_all(), ALL_OFF);
      chk("amid_ledr", 48'(ledr), 48'h0);
      chk("amid_state", 48'(dbg_state), 48'(ST_IDLE));
      req = 4'b1011;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Round robin with full slices: 0, 1, 3, 0
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_grant", 48'(grant), 48'(seq_g[g]));
            chk("rr_busy", 48'(busy), 48'h1);
            chk("rr_hex0", 48'(hex0), (k == 0) ? 48'hFF : 48'(seq_h[g]));
         end
         if (g < 3) begin
            step();
            chk("rr_gap_grant", 48'(grant), 48'h0);
            chk("rr_gap_hex0", 48'(hex0), 48'hFF);
            chk("rr_gap_state", 48'(dbg_state), 48'(ST_BLANK));
         end
      end

      // Early release: owner 0 drops, 1 takes over, 1 drops after two cycles
      req = 4'b1010;
      step();
      chk("early_blank0", 48'(grant), 48'h0);
      step();
      chk("early_own1_a", 48'(grant), 48'b0010);
      step();
      chk("early_own1_b", 48'(grant), 48'b0010);
      req = 4'b1000;
      step();
      chk("early_blank1", 48'(grant), 48'h0);
      chk("early_blank1_st", 48'(dbg_state), 48'(ST_BLANK));
      step();
      chk("early_own3", 48'(grant), 48'b1000);

      // Owner 3 releases; pointer wraps to 0 so 0 wins before 3
      req = 4'b0001;
      step();
      chk("wrap2_blank", 48'(grant), 48'h0);
      req = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("wrap2_own0", 48'(grant), 48'b0001);
      end
      step();
      chk("wrap2_gap", 48'(grant), 48'h0);
      step();
      chk("wrap2_own3", 48'(grant), 48'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
